innings_controller: RTL and testbench
=====================================

INNINGS_CONTROLLER -- requirements
Module: innings_controller

Interface
REQ-001 Parameter BALLS_PER_INNING, default 30, legal balls per inning (1..127).
REQ-002 Parameter MAX_WICKETS, default 10, wickets that end an inning (1..15).
REQ-003 clk_fpga  in  1  single system clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 delivery  in  1  one-cycle pulse, one bowled ball; pulses SHALL be at least 3 cycles apart.
REQ-006 lfsr_out  in  4  outcome code for the ball, valid in the delivery cycle.
REQ-007 nextInning  in  1  one-cycle pulse, starts inning 2 from BREAK.
REQ-008 team1Balls, team2Balls  in  7 each  legal-ball counts from the LED controller; they update 1 cycle after delivery.
REQ-009 teamSwitch  out  1  0 = team 1 batting, 1 = team 2 batting.
REQ-010 inningOver  out  1  current inning has ended.
REQ-011 gameOver  out  1  match complete.
REQ-012 team1Runs, team2Runs  out  9 each  runs scored.
REQ-013 team1Wkts, team2Wkts  out  4 each  wickets lost.
REQ-014 winner  out  2  0 = undecided, 1 = team 1, 2 = team 2, 3 = tie.

Function
REQ-015 Outcome decode: 0-2 = 0 runs; 3-5 = 1; 6-7 = 2; 8 = 3; 9-10 = 4; 11-12 = 6; 13 (wide) = 1 extra; 14 (no ball) = 1 extra; 15 = wicket, 0 runs.
REQ-016 FSM states: INN1, INN1_WAIT, BREAK, INN2, INN2_WAIT, DONE.
REQ-017 In INN1/INN2, delivery with inningOver=0 SHALL add runs to the batting team 1 cycle later (registered); code 15 SHALL increment that team's wickets.
REQ-018 Runs SHALL saturate at 511; wickets SHALL saturate at MAX_WICKETS.
REQ-019 After each delivery the FSM SHALL enter the *_WAIT state for exactly 1 cycle so the ball-count inputs settle; end checks SHALL be evaluated on the following edge.
REQ-020 Inning 1 ends when team1Balls >= BALLS_PER_INNING or team1Wkts == MAX_WICKETS; the FSM then goes to BREAK and asserts inningOver=1 while teamSwitch stays 0.
REQ-021 In BREAK, nextInning SHALL go to INN2 on the next edge with teamSwitch=1 and inningOver=0; all other inputs are ignored.
REQ-022 Inning 2 ends when team2Runs > team1Runs, team2Balls >= BALLS_PER_INNING, or team2Wkts == MAX_WICKETS; the FSM then goes to DONE.
REQ-023 In DONE: gameOver=1 and inningOver=1; winner = 2 if team2Runs > team1Runs, 1 if less, 3 if equal. Held until reset.
REQ-024 If delivery and nextInning are both asserted in BREAK, nextInning SHALL win and the delivery is dropped.
REQ-025 Delivery pulses in WAIT, BREAK or DONE SHALL be ignored.
REQ-026 All outputs SHALL be registered; there are no combinational input-to-output paths.

Reset
REQ-027 Reset SHALL force INN1, all runs/wickets = 0, teamSwitch = 0, inningOver = 0, gameOver = 0, winner = 0, from any state, including mid-WAIT.

Structure
REQ-028 The outcome-code constants (13 = WIDE, 14 = NOBALL, 15 = WICKET) and the state encoding SHALL live in the shared cricket_defs include, also used by the LED controller.
REQ-029 The outcome decode SHALL be a combinational sub-module run_decoder (lfsr_out -> runs[2:0], wicket).

Verification
REQ-030 Reset, then delivery with codes 11, 13, 8 while feeding the ball counts -> team1Runs = 10, team1Wkts = 0.
REQ-031 BALLS_PER_INNING = 6; six code-0 deliveries with team1Balls stepping 1..6 -> inningOver = 1 two cycles after the 6th delivery, teamSwitch = 0; then nextInning -> teamSwitch = 1, inningOver = 0.
REQ-032 MAX_WICKETS = 2; two code-15 deliveries in inning 1 -> BREAK with team1Wkts = 2 and team1Balls < limit.
REQ-033 team1Runs = 6; in inning 2 one code-11 delivery then one code-3 delivery -> gameOver = 1, winner = 2 after the 2nd ball, before the ball limit is reached.
REQ-034 Both innings end with equal runs -> winner = 3; delivery pulses in DONE leave all outputs unchanged.
REQ-035 Assert reset during INN2_WAIT -> all outputs return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/cricket_defs_pkg.sv
// Shared cricket definitions: outcome codes, innings FSM encoding, run saturation.
package cricket_defs_pkg;

   typedef enum logic [2:0] {
      ST_INN1      = 3'd0,
      ST_INN1_WAIT = 3'd1,
      ST_BREAK     = 3'd2,
      ST_INN2      = 3'd3,
      ST_INN2_WAIT = 3'd4,
      ST_DONE      = 3'd5
   } inn_state_t;

   localparam logic [3:0] OC_WIDE   = 4'd13;
   localparam logic [3:0] OC_NOBALL = 4'd14;
   localparam logic [3:0] OC_WICKET = 4'd15;

   localparam logic [1:0] WIN_NONE = 2'd0;
   localparam logic [1:0] WIN_T1   = 2'd1;
   localparam logic [1:0] WIN_T2   = 2'd2;
   localparam logic [1:0] WIN_TIE  = 2'd3;

   localparam logic [8:0] RUNS_MAX = 9'h1FF;

   // Add a ball's runs to a score, pinning at the 9-bit ceiling.
   function automatic logic [8:0] sat_add_runs(input logic [8:0] a, input logic [2:0] b);
      logic [9:0] s;
      s = {1'b0, a} + {7'd0, b};
      return s[9] ? RUNS_MAX : s[8:0];
   endfunction

endpackage

// File: rtl/run_decoder.sv
// Combinational decode of a 4-bit outcome code into runs and a wicket flag.
module run_decoder
   import cricket_defs_pkg::*;
(
   input  logic [3:0] lfsr_out,
   output logic [2:0] runs,
   output logic       wicket
);

   // Map outcome code to runs; extras score one, wicket scores nothing.
   always_comb begin
      runs   = 3'd0;
      wicket = 1'b0;
      case (lfsr_out)
         4'd0, 4'd1, 4'd2:    runs = 3'd0;
         4'd3, 4'd4, 4'd5:    runs = 3'd1;
         4'd6, 4'd7:          runs = 3'd2;
         4'd8:                runs = 3'd3;
         4'd9, 4'd10:         runs = 3'd4;
         4'd11, 4'd12:        runs = 3'd6;
         OC_WIDE, OC_NOBALL:  runs = 3'd1;
         OC_WICKET:           wicket = 1'b1;
         default:             runs = 3'd0;
      endcase
   end

endmodule

// File: rtl/innings_controller.sv
// Two-innings match controller: scores each ball, decides end of innings and the winner.
module innings_controller
   import cricket_defs_pkg::*;
#(
   parameter int BALLS_PER_INNING = 30,
   parameter int MAX_WICKETS      = 10
) (
   input  logic       clk_fpga,
   input  logic       reset,
   input  logic       delivery,
   input  logic [3:0] lfsr_out,
   input  logic       nextInning,
   input  logic [6:0] team1Balls,
   input  logic [6:0] team2Balls,
   output logic       teamSwitch,
   output logic       inningOver,
   output logic       gameOver,
   output logic [8:0] team1Runs,
   output logic [8:0] team2Runs,
   output logic [3:0] team1Wkts,
   output logic [3:0] team2Wkts,
   output logic [1:0] winner
);

   localparam logic [6:0] BALL_LIM = 7'(BALLS_PER_INNING);
   localparam logic [3:0] WKT_LIM  = 4'(MAX_WICKETS);

   inn_state_t state_q, state_d;

   logic       team_switch_q, team_switch_d;
   logic       inning_over_q, inning_over_d;
   logic       game_over_q,   game_over_d;
   logic [8:0] team1_runs_q,  team1_runs_d;
   logic [8:0] team2_runs_q,  team2_runs_d;
   logic [3:0] team1_wkts_q,  team1_wkts_d;
   logic [3:0] team2_wkts_q,  team2_wkts_d;
   logic [1:0] winner_q,      winner_d;

   logic [2:0] dec_runs;
   logic       dec_wkt;
   logic       ball_ok;
   logic       inn1_end;
   logic       inn2_end;

   run_decoder u_dec (
      .lfsr_out (lfsr_out),
      .runs     (dec_runs),
      .wicket   (dec_wkt)
   );

   // A ball only counts while an inning is live and not waiting on ball counts.
   assign ball_ok  = delivery && !inning_over_q &&
                     ((state_q == ST_INN1) || (state_q == ST_INN2));
   // Ball counts are sampled in the WAIT cycle, after the LED controller has updated them.
   assign inn1_end = (team1Balls >= BALL_LIM) || (team1_wkts_q == WKT_LIM);
   assign inn2_end = (team2_runs_q > team1_runs_q) || (team2Balls >= BALL_LIM) ||
                     (team2_wkts_q == WKT_LIM);

   // State register.
   always_ff @(posedge clk_fpga or posedge reset) begin
      if (reset) state_q <= ST_INN1;
      else       state_q <= state_d;
   end

   // Next-state logic: every accepted ball detours through one WAIT cycle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_INN1:      if (ball_ok)    state_d = ST_INN1_WAIT;
         ST_INN1_WAIT: state_d = inn1_end ? ST_BREAK : ST_INN1;
         ST_BREAK:     if (nextInning) state_d = ST_INN2;
         ST_INN2:      if (ball_ok)    state_d = ST_INN2_WAIT;
         ST_INN2_WAIT: state_d = inn2_end ? ST_DONE : ST_INN2;
         ST_DONE:      state_d = ST_DONE;
         default:      state_d = ST_INN1;
      endcase
   end

   // Output/datapath next values: scoring plus the flags raised on state transitions.
   always_comb begin
      team_switch_d = team_switch_q;
      inning_over_d = inning_over_q;
      game_over_d   = game_over_q;
      team1_runs_d  = team1_runs_q;
      team2_runs_d  = team2_runs_q;
      team1_wkts_d  = team1_wkts_q;
      team2_wkts_d  = team2_wkts_q;
      winner_d      = winner_q;

      if (ball_ok) begin
         if (state_q == ST_INN2) begin
            team2_runs_d = sat_add_runs(team2_runs_q, dec_runs);
            if (dec_wkt && (team2_wkts_q < WKT_LIM)) team2_wkts_d = team2_wkts_q + 4'd1;
         end else begin
            team1_runs_d = sat_add_runs(team1_runs_q, dec_runs);
            if (dec_wkt && (team1_wkts_q < WKT_LIM)) team1_wkts_d = team1_wkts_q + 4'd1;
         end
      end

      case (state_q)
         ST_INN1_WAIT: if (inn1_end) inning_over_d = 1'b1;
         ST_BREAK: begin
            if (nextInning) begin
               team_switch_d = 1'b1;
               inning_over_d = 1'b0;
            end
         end
         ST_INN2_WAIT: begin
            if (inn2_end) begin
               inning_over_d = 1'b1;
               game_over_d   = 1'b1;
               if (team2_runs_q > team1_runs_q)      winner_d = WIN_T2;
               else if (team2_runs_q < team1_runs_q) winner_d = WIN_T1;
               else                                  winner_d = WIN_TIE;
            end
         end
         default: ;
      endcase
   end

   // Output and score registers.
   always_ff @(posedge clk_fpga or posedge reset) begin
      if (reset) begin
         team_switch_q <= 1'b0;
         inning_over_q <= 1'b0;
         game_over_q   <= 1'b0;
         team1_runs_q  <= 9'd0;
         team2_runs_q  <= 9'd0;
         team1_wkts_q  <= 4'd0;
         team2_wkts_q  <= 4'd0;
         winner_q      <= WIN_NONE;
      end else begin
         team_switch_q <= team_switch_d;
         inning_over_q <= inning_over_d;
         game_over_q   <= game_over_d;
         team1_runs_q  <= team1_runs_d;
         team2_runs_q  <= team2_runs_d;
         team1_wkts_q  <= team1_wkts_d;
         team2_wkts_q  <= team2_wkts_d;
         winner_q      <= winner_d;
      end
   end

   assign teamSwitch = team_switch_q;
   assign inningOver = inning_over_q;
   assign gameOver   = game_over_q;
   assign team1Runs  = team1_runs_q;
   assign team2Runs  = team2_runs_q;
   assign team1Wkts  = team1_wkts_q;
   assign team2Wkts  = team2_wkts_q;
   assign winner     = winner_q;

endmodule

// File: tb/tb_innings_controller.sv
// Bench: plays the LED controller, predicts the match from the scoring rules, checks every cycle.
module tb_innings_controller;

   localparam int BPI = 6;
   localparam int MW  = 2;

   logic       clk_fpga;
   logic       reset;
   logic       delivery;
   logic [3:0] lfsr_out;
   logic       nextInning;
   logic [6:0] team1Balls;
   logic [6:0] team2Balls;
   logic       teamSwitch, inningOver, gameOver;
   logic [8:0] team1Runs, team2Runs;
   logic [3:0] team1Wkts, team2Wkts;
   logic [1:0] winner;

   innings_controller #(.BALLS_PER_INNING(BPI), .MAX_WICKETS(MW)) dut (
      .clk_fpga   (clk_fpga),
      .reset      (reset),
      .delivery   (delivery),
      .lfsr_out   (lfsr_out),
      .nextInning (nextInning),
      .team1Balls (team1Balls),
      .team2Balls (team2Balls),
      .teamSwitch (teamSwitch),
      .inningOver (inningOver),
      .gameOver   (gameOver),
      .team1Runs  (team1Runs),
      .team2Runs  (team2Runs),
      .team1Wkts  (team1Wkts),
      .team2Wkts  (team2Wkts),
      .winner     (winner)
   );

   initial clk_fpga = 1'b0;
   always #5 clk_fpga = ~clk_fpga;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int RUN_TBL [16] = '{0, 0, 0, 1, 1, 1, 2, 2, 3, 4, 4, 6, 6, 1, 1, 0};
   int e_runs [2];
   int e_wk   [2];
   int e_sw, e_over, e_game, e_win;
   int m_inn;        // 1 or 2: which inning is (or was last) being played
   bit m_live;       // inning accepting balls
   bit m_wait;       // a ball was just scored; end check due on next edge
   bit m_done;
   bit m_acc;        // a ball was accepted on the last edge
   int m_acc_team;
   bit m_acc_legal;

   // Model of the match, advanced once per clock edge from the scoring rules.
   always @(posedge clk_fpga or posedge reset) begin
      if (reset) begin
         e_runs[0] <= 0; e_runs[1] <= 0; e_wk[0] <= 0; e_wk[1] <= 0;
         e_sw <= 0; e_over <= 0; e_game <= 0; e_win <= 0;
         m_inn <= 1; m_live <= 1'b1; m_wait <= 1'b0; m_done <= 1'b0;
         m_acc <= 1'b0; m_acc_team <= 0; m_acc_legal <= 1'b0;
      end else begin
         m_acc <= 1'b0;
         if (m_wait) begin
            m_wait <= 1'b0;
            if (m_inn == 1) begin
               if (int'(team1Balls) >= BPI || e_wk[0] == MW) begin
                  m_live <= 1'b0; e_over <= 1;
               end
            end else if (e_runs[1] > e_runs[0] || int'(team2Balls) >= BPI || e_wk[1] == MW) begin
               m_live <= 1'b0; m_done <= 1'b1; e_over <= 1; e_game <= 1;
               e_win <= (e_runs[1] > e_runs[0]) ? 2 : (e_runs[1] < e_runs[0]) ? 1 : 3;
            end
         end else if (m_live && delivery) begin
            e_runs[m_inn-1] <= (e_runs[m_inn-1] + RUN_TBL[lfsr_out] > 511) ? 511
                               : e_runs[m_inn-1] + RUN_TBL[lfsr_out];
            if (lfsr_out == 4'd15 && e_wk[m_inn-1] < MW) e_wk[m_inn-1] <= e_wk[m_inn-1] + 1;
            m_wait <= 1'b1;
            m_acc <= 1'b1;
            m_acc_team <= m_inn - 1;
            m_acc_legal <= (lfsr_out != 4'd13) && (lfsr_out != 4'd14);
         end else if (!m_live && !m_done && m_inn == 1 && nextInning) begin
            m_inn <= 2; m_live <= 1'b1; e_over <= 0; e_sw <= 1;
         end
      end
   end

   // Per-cycle comparison of every output against the model.
   always @(negedge clk_fpga) begin
      if (chk_en) begin
         chk("teamSwitch", int'(teamSwitch), e_sw);
         chk("inningOver", int'(inningOver), e_over);
         chk("gameOver",   int'(gameOver),   e_game);
         chk("team1Runs",  int'(team1Runs),  e_runs[0]);
         chk("team2Runs",  int'(team2Runs),  e_runs[1]);
         chk("team1Wkts",  int'(team1Wkts),  e_wk[0]);
         chk("team2Wkts",  int'(team2Wkts),  e_wk[1]);
         chk("winner",     int'(winner),     e_win);
      end
   end

   // ---------------- stimulus helpers ----------------
   // One clock; afterwards act as the LED controller and count the legal ball.
   task automatic tick();
      @(posedge clk_fpga);
      #2;
      if (m_acc && m_acc_legal) begin
         if (m_acc_team == 0) team1Balls = team1Balls + 7'd1;
         else                 team2Balls = team2Balls + 7'd1;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1; delivery = 1'b0; nextInning = 1'b0; lfsr_out = 4'd0;
      team1Balls = 7'd0; team2Balls = 7'd0;
      tick(); tick();
      reset = 1'b0;
      chk_en = 1'b1;
   endtask

   // Delivery pulse followed by two idle cycles (keeps pulses 3 cycles apart).
   task automatic deliver(input int code, input bit ni);
      delivery = 1'b1; lfsr_out = 4'(code); nextInning = ni;
      tick();
      delivery = 1'b0; nextInning = 1'b0;
      tick(); tick();
   endtask

   task automatic next_inn();
      nextInning = 1'b1;
      tick();
      nextInning = 1'b0;
      tick();
   endtask

   initial begin
      reset = 1'b0; delivery = 1'b0; nextInning = 1'b0; lfsr_out = 4'd0;
      team1Balls = 7'd0; team2Balls = 7'd0;

      // Reset state and three-ball scoring: 6 + wide 1 + 3 = 10.
      do_reset();
      chk("rst_runs1", int'(team1Runs), 0);
      chk("rst_winner", int'(winner), 0);
      chk("rst_switch", int'(teamSwitch), 0);
      deliver(11, 1'b0); deliver(13, 1'b0); deliver(8, 1'b0);
      chk("s1_runs1", int'(team1Runs), 10);
      chk("s1_wkts1", int'(team1Wkts), 0);

      // Ball limit: inningOver exactly two cycles after the 6th ball.
      do_reset();
      for (int i = 0; i < 5; i++) deliver(0, 1'b0);
      delivery = 1'b1; lfsr_out = 4'd0;
      tick();
      delivery = 1'b0;
      chk("s2_over_1cyc", int'(inningOver), 0);
      tick();
      chk("s2_over_2cyc", int'(inningOver), 1);
      chk("s2_switch_brk", int'(teamSwitch), 0);
      chk("s2_balls1", int'(team1Balls), 6);
      tick();
      deliver(12, 1'b0);                       // ignored in BREAK
      chk("s2_brk_ign", int'(team1Runs), 0);
      deliver(12, 1'b1);                       // nextInning wins over delivery
      chk("s2_switch", int'(teamSwitch), 1);
      chk("s2_over_clr", int'(inningOver), 0);
      chk("s2_drop", int'(team2Runs), 0);

      // Wicket limit ends inning 1 before the ball limit.
      do_reset();
      deliver(15, 1'b0);
      chk("s3_over_w1", int'(inningOver), 0);
      deliver(15, 1'b0);
      chk("s3_wkts1", int'(team1Wkts), 2);
      chk("s3_over", int'(inningOver), 1);
      chk("s3_balls_lt", int'(int'(team1Balls) < BPI), 1);

      // Chase: 6 to beat, 6 then 1 -> team 2 wins early.
      do_reset();
      deliver(11, 1'b0); deliver(15, 1'b0); deliver(15, 1'b0);
      next_inn();
      deliver(11, 1'b0);
      chk("s4_game_mid", int'(gameOver), 0);
      deliver(3, 1'b0);
      chk("s4_game", int'(gameOver), 1);
      chk("s4_winner", int'(winner), 2);
      chk("s4_runs2", int'(team2Runs), 7);

      // Tie, then deliveries in DONE change nothing.
      do_reset();
      deliver(9, 1'b0); deliver(15, 1'b0); deliver(15, 1'b0);
      next_inn();
      deliver(10, 1'b0); deliver(15, 1'b0); deliver(15, 1'b0);
      chk("s5_winner", int'(winner), 3);
      deliver(11, 1'b0); deliver(15, 1'b0);
      chk("s5_done_runs2", int'(team2Runs), 4);
      chk("s5_done_wkts2", int'(team2Wkts), 2);
      chk("s5_done_win", int'(winner), 3);
      chk("s5_done_over", int'(inningOver), 1);

      // Asynchronous reset in the middle of an INN2 WAIT cycle.
      do_reset();
      deliver(11, 1'b0); deliver(15, 1'b0); deliver(15, 1'b0);
      next_inn();
      delivery = 1'b1; lfsr_out = 4'd11;
      tick();
      delivery = 1'b0;
      #1 reset = 1'b1; team1Balls = 7'd0; team2Balls = 7'd0;
      #1;
      chk("s6_runs1", int'(team1Runs), 0);
      chk("s6_runs2", int'(team2Runs), 0);
      chk("s6_switch", int'(teamSwitch), 0);
      chk("s6_over", int'(inningOver), 0);
      chk("s6_wkts1", int'(team1Wkts), 0);
      #3 reset = 1'b0;
      tick();

      // Saturation: extras never use up balls, so run the score past 511.
      do_reset();
      for (int i = 0; i < 515; i++) deliver((i % 2 == 0) ? 13 : 14, 1'b0);
      chk("s7_sat", int'(team1Runs), 511);

      // Randomized matches.
      for (int m = 0; m < 20; m++) begin
         do_reset();
         for (int s = 0; s < 80; s++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 7)       deliver(int'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0));
            else if (r < 9)  next_inn();
            else             tick();
         end
      end

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
